ddram_arbiter: RTL and testbench

Two-client arbiter sharing the single 64-bit DDRAM burst port of emu between the video scanout reader (read-only, latency-critical) and the MPEG2 decoder memory port (read/write). Sequences one command at a time onto the DDRAM bus, honours DDRAM_BUSY back-pressure, counts burst beats and steers read data back to the owning client. Sits in emu between the clients and the DDRAM_* top-level ports; runs on the DDRAM_CLK domain.

---
 rtl/ddram_arbiter.sv | 154 +++++++++++++++
 tb/tb_ddram_arbiter.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddram_arbiter.sv
// Two-client DDRAM burst-port arbiter: video scanout reads and MPEG2 decoder reads/writes.
// One command in flight at a time; read data is steered back to whichever client owns the burst.
`timescale 1ns/1ps
module ddram_arbiter #(
    parameter int MAX_VIDEO_RUN = 4,
    parameter int BURST_W       = 8
) (
    input  logic               clk_sys,
    input  logic               reset_n,

    input  logic               v_req,
    input  logic [28:0]        v_addr,
    input  logic [BURST_W-1:0] v_burst,
    output logic               v_gnt,
    output logic               v_rvalid,

    input  logic               d_req,
    input  logic               d_we,
    input  logic [28:0]        d_addr,
    input  logic [BURST_W-1:0] d_burst,
    input  logic [63:0]        d_din,
    input  logic [7:0]         d_be,
    output logic               d_gnt,
    output logic               d_wbeat,
    output logic               d_rvalid,
    output logic [63:0]        rd_data,

    input  logic               DDRAM_BUSY,
    input  logic [63:0]        DDRAM_DOUT,
    input  logic               DDRAM_DOUT_READY,
    output logic [28:0]        DDRAM_ADDR,
    output logic [BURST_W-1:0] DDRAM_BURSTCNT,
    output logic               DDRAM_RD,
    output logic               DDRAM_WE,
    output logic [63:0]        DDRAM_DIN,
    output logic [7:0]         DDRAM_BE,

    output logic [1:0]         state_dbg
);

    typedef enum logic [1:0] {IDLE, RD_CMD, RD_DATA, WR} state_t;

    localparam int RUN_W = $clog2(MAX_VIDEO_RUN + 1);

    state_t               state;
    logic [RUN_W-1:0]     run_cnt;
    logic [BURST_W-1:0]   beat_cnt;
    logic                 owner_v;
    logic                 grant_v;
    logic                 grant_d;
    logic                 rd_beat;
    logic                 wr_beat;
    logic                 last_beat;

    function automatic logic [BURST_W-1:0] fix_burst(input logic [BURST_W-1:0] b);
        return (b == '0) ? BURST_W'(1) : b;
    endfunction

    // Handshake: a command is accepted in any cycle where RD/WE is high and DDRAM_BUSY is low;
    // the owner's gnt (and d_wbeat for write beats) is high exactly in those accept cycles.
    always_comb begin
        grant_v   = v_req && (!d_req || (run_cnt < RUN_W'(MAX_VIDEO_RUN)));
        grant_d   = !grant_v && d_req;
        rd_beat   = DDRAM_DOUT_READY &&
                    (((state == RD_CMD) && !DDRAM_BUSY) || (state == RD_DATA));
        wr_beat   = (state == WR) && !DDRAM_BUSY;
        last_beat = ((beat_cnt + BURST_W'(1)) == DDRAM_BURSTCNT);
        v_gnt     = (state == RD_CMD) && !DDRAM_BUSY && owner_v;
        d_gnt     = ((state == RD_CMD) && !DDRAM_BUSY && !owner_v) ||
                    (wr_beat && (beat_cnt == '0));
        d_wbeat   = wr_beat;
        DDRAM_DIN = (state == WR) ? d_din : 64'h0;
        DDRAM_BE  = (state == WR) ? d_be  : 8'h0;
        state_dbg = state;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            run_cnt        <= '0;
            beat_cnt       <= '0;
            owner_v        <= 1'b0;
            DDRAM_ADDR     <= '0;
            DDRAM_BURSTCNT <= '0;
            DDRAM_RD       <= 1'b0;
            DDRAM_WE       <= 1'b0;
            rd_data        <= '0;
            v_rvalid       <= 1'b0;
            d_rvalid       <= 1'b0;
        end else begin
            v_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            if (rd_beat) begin
                rd_data  <= DDRAM_DOUT;
                v_rvalid <= owner_v;
                d_rvalid <= !owner_v;
                beat_cnt <= beat_cnt + BURST_W'(1);
            end

            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (grant_v) begin
                        owner_v        <= 1'b1;
                        DDRAM_ADDR     <= v_addr;
                        DDRAM_BURSTCNT <= fix_burst(v_burst);
                        DDRAM_RD       <= 1'b1;
                        state          <= RD_CMD;
                        // Run only grows while the decoder is actually being kept waiting.
                        if (!d_req)
                            run_cnt <= '0;
                        else if (run_cnt != RUN_W'(MAX_VIDEO_RUN))
                            run_cnt <= run_cnt + RUN_W'(1);
                    end else if (grant_d) begin
                        owner_v        <= 1'b0;
                        DDRAM_ADDR     <= d_addr;
                        DDRAM_BURSTCNT <= fix_burst(d_burst);
                        run_cnt        <= '0;
                        if (d_we) begin
                            DDRAM_WE <= 1'b1;
                            state    <= WR;
                        end else begin
                            DDRAM_RD <= 1'b1;
                            state    <= RD_CMD;
                        end
                    end else begin
                        run_cnt <= '0;
                    end
                end
                RD_CMD: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= (rd_beat && last_beat) ? IDLE : RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rd_beat && last_beat)
                        state <= IDLE;
                end
                WR: begin
                    if (wr_beat) begin
                        beat_cnt <= beat_cnt + BURST_W'(1);
                        if (last_beat) begin
                            DDRAM_WE <= 1'b0;
                            state    <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddram_arbiter.sv
// Scoreboarded bench for ddram_arbiter: client drivers push expectations, a negedge monitor
// pops and compares them, and a small DDRAM model returns address-derived read data.
`timescale 1ns/1ps
module tb_ddram_arbiter;

    localparam int BW = 8;

    logic          clk_sys = 1'b0;
    logic          reset_n;
    logic          v_req;
    logic [28:0]   v_addr;
    logic [BW-1:0] v_burst;
    logic          v_gnt, v_rvalid;
    logic          d_req, d_we;
    logic [28:0]   d_addr;
    logic [BW-1:0] d_burst;
    logic [63:0]   d_din;
    logic [7:0]    d_be;
    logic          d_gnt, d_wbeat, d_rvalid;
    logic [63:0]   rd_data;
    logic          DDRAM_BUSY;
    logic [63:0]   DDRAM_DOUT;
    logic          DDRAM_DOUT_READY;
    logic [28:0]   DDRAM_ADDR;
    logic [BW-1:0] DDRAM_BURSTCNT;
    logic          DDRAM_RD, DDRAM_WE;
    logic [63:0]   DDRAM_DIN;
    logic [7:0]    DDRAM_BE;
    logic [1:0]    state_dbg;

    ddram_arbiter #(.MAX_VIDEO_RUN(4), .BURST_W(BW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .v_req(v_req), .v_addr(v_addr), .v_burst(v_burst), .v_gnt(v_gnt), .v_rvalid(v_rvalid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_burst(d_burst), .d_din(d_din),
        .d_be(d_be), .d_gnt(d_gnt), .d_wbeat(d_wbeat), .d_rvalid(d_rvalid), .rd_data(rd_data),
        .DDRAM_BUSY(DDRAM_BUSY), .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_RD(DDRAM_RD),
        .DDRAM_WE(DDRAM_WE), .DDRAM_DIN(DDRAM_DIN), .DDRAM_BE(DDRAM_BE), .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk_sys = ~clk_sys;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int errors = 0;
    int checks = 0;
    logic [63:0]  v_exp_q[$];
    logic [63:0]  d_exp_q[$];
    logic [36:0]  v_cmd_q[$];
    logic [36:0]  d_cmd_q[$];
    logic [100:0] w_exp_q[$];
    logic         grant_log[$];
    int rd_cyc = 0, we_cyc = 0, vg_n = 0, dg_n = 0, wb_n = 0, vr_n = 0, dr_n = 0, stab_err = 0;
    logic busy_force = 1'b0, busy_rand = 1'b0, stray_en = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with empty expected queue", name);
    endtask

    function automatic logic [63:0] mem_word(input logic [28:0] a);
        return {3'b000, a, 3'b101, ~a};
    endfunction

    // ---------------- monitor ----------------
    initial begin : monitor
        logic        act_prev;
        logic [36:0] prev_cmd;
        act_prev = 1'b0;
        prev_cmd = '0;
        forever begin
            @(negedge clk_sys);
            if (!reset_n) begin
                act_prev = 1'b0;
            end else begin
                if (DDRAM_RD) rd_cyc++;
                if (DDRAM_WE) we_cyc++;
                if ((DDRAM_RD || DDRAM_WE) && act_prev && ({DDRAM_ADDR, DDRAM_BURSTCNT} != prev_cmd))
                    stab_err++;
                act_prev = DDRAM_RD || DDRAM_WE;
                prev_cmd = {DDRAM_ADDR, DDRAM_BURSTCNT};

                if (v_gnt) begin
                    vg_n++;
                    grant_log.push_back(1'b1);
                    check("v_gnt_rd_not_busy", {DDRAM_RD, DDRAM_BUSY}, 2'b10);
                    if (v_cmd_q.size() == 0) unexpected("v_cmd");
                    else check("v_cmd", {DDRAM_ADDR, DDRAM_BURSTCNT}, v_cmd_q.pop_front());
                end
                if (d_gnt) begin
                    dg_n++;
                    grant_log.push_back(1'b0);
                    if (d_cmd_q.size() == 0) unexpected("d_cmd");
                    else check("d_cmd", {DDRAM_ADDR, DDRAM_BURSTCNT}, d_cmd_q.pop_front());
                end
                if (v_rvalid) begin
                    vr_n++;
                    if (v_exp_q.size() == 0) unexpected("v_rdata");
                    else check("v_rdata", rd_data, v_exp_q.pop_front());
                end
                if (d_rvalid) begin
                    dr_n++;
                    if (d_exp_q.size() == 0) unexpected("d_rdata");
                    else check("d_rdata", rd_data, d_exp_q.pop_front());
                end
                if (v_rvalid && d_rvalid) check("rvalid_exclusive", 1'b1, 1'b0);
                if (d_wbeat || (DDRAM_WE && !DDRAM_BUSY)) begin
                    check("wbeat_vs_we", d_wbeat, DDRAM_WE && !DDRAM_BUSY);
                    if (d_wbeat) begin
                        wb_n++;
                        if (w_exp_q.size() == 0) unexpected("wr_beat");
                        else check("wr_beat", {DDRAM_ADDR, DDRAM_DIN, DDRAM_BE}, w_exp_q.pop_front());
                    end
                end
            end
        end
    end

    // ---------------- DDRAM model ----------------
    initial begin : ddram_model
        int          pend;
        int          ridx;
        logic [28:0] raddr;
        logic        acc, taken;
        logic [28:0] acc_addr;
        logic [BW-1:0] acc_n;
        pend = 0; ridx = 0; raddr = '0;
        DDRAM_BUSY = 1'b0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 1'b0;
        forever begin
            @(negedge clk_sys);
            acc      = DDRAM_RD && !DDRAM_BUSY;
            acc_addr = DDRAM_ADDR;
            acc_n    = DDRAM_BURSTCNT;
            taken    = DDRAM_DOUT_READY && (pend > 0);
            @(posedge clk_sys);
            #1;
            if (!reset_n) begin
                pend = 0;
            end else begin
                if (taken) begin pend--; ridx++; end
                if (acc) begin pend = int'(acc_n); ridx = 0; raddr = acc_addr; end
            end
            if (pend > 0) begin
                DDRAM_DOUT_READY = busy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                DDRAM_DOUT       = mem_word(raddr + 29'(ridx));
            end else if (stray_en && !DDRAM_RD && ($urandom_range(0, 4) == 0)) begin
                DDRAM_DOUT_READY = 1'b1;
                DDRAM_DOUT       = {$urandom, $urandom};
            end else begin
                DDRAM_DOUT_READY = 1'b0;
            end
            DDRAM_BUSY = busy_force || (busy_rand && ($urandom_range(0, 3) == 0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic v_rd(input logic [28:0] a, input logic [BW-1:0] b, input int gap);
        int n; logic got;
        repeat (gap) begin @(posedge clk_sys); #1; end
        n = (b == 0) ? 1 : int'(b);
        v_cmd_q.push_back({a, BW'(n)});
        for (int k = 0; k < n; k++) v_exp_q.push_back(mem_word(a + 29'(k)));
        v_addr = a; v_burst = b; v_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk_sys);
            got = v_gnt;
        end
        check("v_gnt_wait", got, 1'b1);
        @(posedge clk_sys); #1;
        v_req = 1'b0;
    endtask

    task automatic d_rd(input logic [28:0] a, input logic [BW-1:0] b, input int gap);
        int n; logic got;
        repeat (gap) begin @(posedge clk_sys); #1; end
        n = (b == 0) ? 1 : int'(b);
        d_cmd_q.push_back({a, BW'(n)});
        for (int k = 0; k < n; k++) d_exp_q.push_back(mem_word(a + 29'(k)));
        d_addr = a; d_burst = b; d_we = 1'b0; d_req = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk_sys);
            got = d_gnt;
        end
        check("d_gnt_wait", got, 1'b1);
        @(posedge clk_sys); #1;
        d_req = 1'b0;
    endtask

    task automatic d_wr(input logic [28:0] a, input logic [BW-1:0] b, input int gap);
        logic [63:0] dq[$];
        logic [7:0]  bq[$];
        int n, i, t;
        repeat (gap) begin @(posedge clk_sys); #1; end
        n = (b == 0) ? 1 : int'(b);
        for (int k = 0; k < n; k++) begin
            dq.push_back({$urandom, $urandom});
            bq.push_back(8'($urandom));
            w_exp_q.push_back({a, dq[k], bq[k]});
        end
        d_cmd_q.push_back({a, BW'(n)});
        d_addr = a; d_burst = b; d_we = 1'b1; d_din = dq[0]; d_be = bq[0]; d_req = 1'b1;
        i = 0; t = 0;
        while (i < n && t < 2000) begin
            @(negedge clk_sys);
            t++;
            if (d_wbeat) i++;
            @(posedge clk_sys); #1;
            if (i > 0) d_req = 1'b0;
            if (i < n) begin d_din = dq[i]; d_be = bq[i]; end
        end
        check("d_wr_beats", 32'(i), 32'(n));
        d_we = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((v_exp_q.size() + d_exp_q.size() + w_exp_q.size() + v_cmd_q.size() + d_cmd_q.size()) != 0
               && t < 3000) begin
            @(posedge clk_sys);
            t++;
        end
        check("drain_done", t < 3000, 1'b1);
        repeat (3) @(posedge clk_sys);
        #1;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int s_rd, s_we, s_vg, s_wb, s_vr, s_dr, n, run;
        logic exp_v;
        logic got;
        reset_n = 1'b0;
        v_req = 1'b0; v_addr = '0; v_burst = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_burst = '0; d_din = '0; d_be = '0;
        repeat (3) @(negedge clk_sys);
        check("rst_rd_we", {DDRAM_RD, DDRAM_WE}, 2'b00);
        check("rst_addr_burst", {DDRAM_ADDR, DDRAM_BURSTCNT}, 37'h0);
        check("rst_handshakes", {v_gnt, v_rvalid, d_gnt, d_wbeat, d_rvalid}, 5'b0);
        check("rst_rd_data", rd_data, 64'h0);
        check("rst_state", state_dbg, 2'd0);
        @(posedge clk_sys); #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk_sys); #1;

        // single video read, burst 4, no back-pressure
        s_rd = rd_cyc; s_vg = vg_n; s_vr = vr_n; s_dr = dr_n;
        v_rd(29'h0001000, 8'd4, 0);
        drain();
        check("t1_rd_cycles", rd_cyc - s_rd, 1);
        check("t1_v_gnt", vg_n - s_vg, 1);
        check("t1_v_rvalid", vr_n - s_vr, 4);
        check("t1_d_rvalid", dr_n - s_dr, 0);
        check("t1_idle", state_dbg, 2'd0);

        // decoder write burst 3 with two busy cycles after the first beat
        s_we = we_cyc; s_wb = wb_n; stab_err = 0;
        fork
            d_wr(29'h0123456, 8'd3, 0);
        join_none
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk_sys);
            got = d_wbeat;
        end
        check("t2_first_beat", got, 1'b1);
        busy_force = 1'b1;
        repeat (2) @(posedge clk_sys);
        #2;
        busy_force = 1'b0;
        drain();
        check("t2_we_cycles", we_cyc - s_we, 5);
        check("t2_wbeats", wb_n - s_wb, 3);
        check("t2_addr_stable", stab_err, 0);

        // continuous competition with burst-1 reads
        grant_log.delete();
        fork
            begin
                for (int k = 0; k < 8; k++) v_rd(29'($urandom), 8'd1, 0);
            end
            begin
                for (int k = 0; k < 2; k++) d_rd(29'($urandom), 8'd1, 0);
            end
        join
        drain();
        check("t3_grant_count", grant_log.size(), 10);
        run = 0;
        for (int k = 0; k < 10 && k < grant_log.size(); k++) begin
            exp_v = (run < 4);
            run   = exp_v ? run + 1 : 0;
            check($sformatf("t3_grant_%0d", k), grant_log[k], exp_v);
        end

        // burst 0 is treated as a single beat
        s_vr = vr_n;
        v_rd(29'h1FFFFFF0, 8'd0, 0);
        drain();
        check("t4_one_beat", vr_n - s_vr, 1);

        // ten busy cycles while the read command is presented
        s_rd = rd_cyc; s_vg = vg_n; stab_err = 0;
        busy_force = 1'b1;
        fork
            v_rd(29'h0ABCDEF, 8'd2, 0);
        join_none
        got = 1'b0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk_sys);
            got = DDRAM_RD;
        end
        check("t5_rd_seen", got, 1'b1);
        n = 1;
        check("t5_no_gnt_busy", v_gnt, 1'b0);
        while (n < 10) begin
            @(negedge clk_sys);
            n++;
            check("t5_no_gnt_busy", {DDRAM_RD, v_gnt}, 2'b10);
        end
        busy_force = 1'b0;
        drain();
        check("t5_rd_cycles", rd_cyc - s_rd, 11);
        check("t5_v_gnt", vg_n - s_vg, 1);
        check("t5_stable", stab_err, 0);

        // reset during the second beat of a 4-beat write
        d_cmd_q.push_back({29'h0055AA0, 8'd4});
        w_exp_q.push_back({29'h0055AA0, 64'h1111_2222_3333_4444, 8'hFF});
        w_exp_q.push_back({29'h0055AA0, 64'h5555_6666_7777_8888, 8'h0F});
        d_addr = 29'h0055AA0; d_burst = 8'd4; d_we = 1'b1;
        d_din = 64'h1111_2222_3333_4444; d_be = 8'hFF; d_req = 1'b1;
        n = 0;
        for (int t = 0; t < 100 && n < 2; t++) begin
            @(negedge clk_sys);
            if (d_wbeat) n++;
            if (n == 1) begin
                @(posedge clk_sys); #1;
                d_req = 1'b0; d_din = 64'h5555_6666_7777_8888; d_be = 8'h0F;
                n = 11;
            end
            if (n == 12) n = 2;
            if (n == 11) n = 1;
        end
        check("t6_two_beats", n, 2);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_we", {DDRAM_WE, d_wbeat, d_gnt}, 3'b000);
        check("t6_rst_cmd", {DDRAM_ADDR, DDRAM_BURSTCNT, DDRAM_BE}, 45'h0);
        check("t6_rst_state", state_dbg, 2'd0);
        d_we = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        s_we = we_cyc; s_vr = vr_n;
        v_rd(29'h0000777, 8'd3, 1);
        drain();
        check("t6_no_more_we", we_cyc - s_we, 0);
        check("t6_after_reset_read", vr_n - s_vr, 3);

        // randomized mix with back-pressure and stray read-valid strobes
        busy_rand = 1'b1;
        stray_en  = 1'b1;
        fork
            begin
                for (int k = 0; k < 30; k++)
                    v_rd(29'($urandom), BW'($urandom_range(0, 6)), $urandom_range(0, 5));
            end
            begin
                for (int k = 0; k < 30; k++) begin
                    if ($urandom_range(0, 1) == 1)
                        d_wr(29'($urandom), BW'($urandom_range(0, 6)), $urandom_range(0, 5));
                    else
                        d_rd(29'($urandom), BW'($urandom_range(0, 6)), $urandom_range(0, 5));
                end
            end
        join
        drain();
        busy_rand = 1'b0;
        stray_en  = 1'b0;

        check("final_v_exp_empty", v_exp_q.size(), 0);
        check("final_d_exp_empty", d_exp_q.size(), 0);
        check("final_w_exp_empty", w_exp_q.size(), 0);
        check("final_idle", state_dbg, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
